// File: rtl/usb_uart_pkg.sv
// Shared UART-side definitions for the usb_uart byte pipeline: serialiser state
// encoding, default line/clock rates and the bit-period helper.
package usb_uart_pkg;

    localparam int DEFAULT_CLK_HZ = 48_000_000;
    localparam int DEFAULT_BAUD   = 115_200;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_t;

    // Rounded to the nearest whole clock; no fractional accumulation downstream.
    function automatic int clks_per_bit(input int clk_hz, input int baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/sync_byte_fifo.sv
// Single-clock byte FIFO with registered occupancy count; pushes when full and
// pops when empty are ignored, so callers may drive push/pop unconditionally.
module sync_byte_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                     clk_48mhz,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == FULL_COUNT);
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // DEPTH is a power of two, so pointers wrap by plain overflow.
    always_ff @(posedge clk_48mhz or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk_48mhz) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/usb_uart_tx_bridge.sv
// Drains host->device bytes from the uart_out stream into a FIFO and serialises
// them onto an 8N1 (or 8N2) TX pin, back-to-back with no idle gap when queued.
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   ST_IDLE  | line high, waiting for a queued byte
//   ST_START | start bit (low) for one bit period
//   ST_DATA  | 8 data bits, LSB first
//   ST_STOP  | STOP_BITS high periods; chains straight into next start
module usb_uart_tx_bridge
    import usb_uart_pkg::*;
#(
    parameter int CLK_HZ     = DEFAULT_CLK_HZ,
    parameter int BAUD       = DEFAULT_BAUD,
    parameter int FIFO_DEPTH = 16,
    parameter int STOP_BITS  = 1
) (
    input  logic                           clk_48mhz,
    input  logic                           reset_n,
    input  logic [7:0]                     uart_in_data,
    input  logic                           uart_in_valid,
    output logic                           uart_in_ready,
    output logic                           tx,
    output logic                           busy,
    output logic [$clog2(FIFO_DEPTH):0]    fifo_count
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD);
    localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       STOP_LAST = 3'(STOP_BITS - 1);

    tx_state_t        state;
    logic [7:0]       shift_reg;
    logic [2:0]       bit_cnt;
    logic [CNT_W-1:0] baud_cnt;
    logic             baud_end;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [7:0]       fifo_rd_data;

    sync_byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk_48mhz (clk_48mhz),
        .reset_n   (reset_n),
        .push      (uart_in_valid),
        .push_data (uart_in_data),
        .pop       (fifo_pop),
        .pop_data  (fifo_rd_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign uart_in_ready = !fifo_full;
    assign baud_end      = (baud_cnt == BAUD_LAST);

    // Pop from IDLE, or at the very end of the last stop period to chain frames.
    always_comb begin
        fifo_pop = 1'b0;
        if (!fifo_empty) begin
            if (state == ST_IDLE)
                fifo_pop = 1'b1;
            else if (state == ST_STOP && baud_end && bit_cnt == STOP_LAST)
                fifo_pop = 1'b1;
        end
    end

    always_ff @(posedge clk_48mhz or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            tx        <= 1'b1;
            busy      <= 1'b0;
            shift_reg <= '0;
            bit_cnt   <= '0;
            baud_cnt  <= '0;
        end else begin
            busy <= (state != ST_IDLE) || !fifo_empty;
            case (state)
                ST_IDLE: begin
                    tx <= 1'b1;
                    if (fifo_pop) begin
                        state     <= ST_START;
                        shift_reg <= fifo_rd_data;
                        tx        <= 1'b0;
                        baud_cnt  <= '0;
                        bit_cnt   <= '0;
                    end
                end
                ST_START: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        state    <= ST_DATA;
                        tx       <= shift_reg[0];
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end
                ST_DATA: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        if (bit_cnt == 3'd7) begin
                            bit_cnt <= '0;
                            state   <= ST_STOP;
                            tx      <= 1'b1;
                        end else begin
                            bit_cnt   <= bit_cnt + 3'd1;
                            shift_reg <= {1'b0, shift_reg[7:1]};
                            tx        <= shift_reg[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end
                ST_STOP: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        if (bit_cnt == STOP_LAST) begin
                            bit_cnt <= '0;
                            if (fifo_pop) begin
                                state     <= ST_START;
                                shift_reg <= fifo_rd_data;
                                tx        <= 1'b0;
                            end else begin
                                state <= ST_IDLE;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
